// File: rtl/op_unit_arbiter.sv
// rtl/op_unit_arbiter.sv - round-robin arbiter/sequencer sharing one registered op unit
// Optional feature: OP_ARB_LOCK_EN adds the lock input (re-grant the last winner).
module op_unit_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int OPW      = 3,
    parameter int UNIT_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*OPW-1:0]   req_op,
    input  logic [N_REQ*WIDTH-1:0] req_data,
`ifdef OP_ARB_LOCK_EN
    input  logic [N_REQ-1:0]       lock,
`endif
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   busy,
    output logic [WIDTH-1:0]       unit_in,
    output logic [OPW-1:0]         unit_op,
    input  logic [WIDTH-1:0]       unit_out
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(UNIT_LAT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    w_q, w_d, last_q, last_d, win, cand;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] unit_in_q, unit_in_d, rsp_data_q, rsp_data_d;
    logic [OPW-1:0]   unit_op_q, unit_op_d;
    logic             busy_q, busy_d, found;
`ifdef OP_ARB_LOCK_EN
    logic             lock_hold_q, lock_hold_d;
`endif

    // Search upward from last+1, wrapping; last itself is checked last.
    always_comb begin
        win   = last_q;
        cand  = last_q;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = IW'((int'(last_q) + i) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
`ifdef OP_ARB_LOCK_EN
        if (lock_hold_q && req[w_q]) begin
            win = w_q;
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        gnt_d       = '0;
        rsp_valid_d = '0;
        unit_in_d   = unit_in_q;
        unit_op_d   = unit_op_q;
        rsp_data_d  = rsp_data_q;
`ifdef OP_ARB_LOCK_EN
        lock_hold_d = lock_hold_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    w_d       = win;
                    last_d    = win;
                    unit_in_d = req_data[int'(win)*WIDTH +: WIDTH];
                    unit_op_d = req_op[int'(win)*OPW +: OPW];
                    gnt_d     = N_REQ'(1) << win;
                    state_d   = S_ISSUE;
`ifdef OP_ARB_LOCK_EN
                    lock_hold_d = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                cnt_d   = CW'(UNIT_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_d  = unit_out;
                    rsp_valid_d = N_REQ'(1) << w_q;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
`ifdef OP_ARB_LOCK_EN
                lock_hold_d = lock[w_q];
`endif
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            w_q         <= '0;
            last_q      <= IW'(N_REQ - 1);
            cnt_q       <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            unit_in_q   <= '0;
            unit_op_q   <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
`ifdef OP_ARB_LOCK_EN
            lock_hold_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            rsp_valid_q <= rsp_valid_d;
            unit_in_q   <= unit_in_d;
            unit_op_q   <= unit_op_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
`ifdef OP_ARB_LOCK_EN
            lock_hold_q <= lock_hold_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign unit_in   = unit_in_q;
    assign unit_op   = unit_op_q;
endmodule

// File: tb/tb_op_unit_arbiter.sv
// tb/tb_op_unit_arbiter.sv - scoreboard bench for op_unit_arbiter (UNIT_LAT=1 and UNIT_LAT=3)
module tb_op_unit_arbiter;
    typedef struct {
        int         idx;
        logic [7:0] din;
        logic [2:0] op;
        logic [7:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic [3:0]  a_req = '0, b_req = '0, a_lock = '0;
    logic [11:0] a_op = '0, b_op = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic [3:0]  a_gnt, a_rv, b_gnt, b_rv;
    logic [7:0]  a_rd, a_ui, b_rd, b_ui;
    logic [2:0]  a_uo, b_uo;
    logic        a_busy, b_busy;
    logic [7:0]  pa, pb0, pb1, pb2;

    exp_t qa_g[$], qa_r[$], qb_g[$], qb_r[$];
    int   ga_cyc, gb_cyc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_op(input logic [7:0] a, input logic [2:0] op);
        case (op)
            3'd0: return a;
            3'd1: return a + 8'd1;
            3'd2: return ~a;
            3'd3: return {a[6:0], 1'b0};
            3'd4: return {1'b0, a[7:1]};
            3'd5: return a ^ 8'h5A;
            3'd6: return {a[3:0], a[7:4]};
            default: return 8'd0 - a;
        endcase
    endfunction

    // Registered op units: latency 1 for dut A, latency 3 for dut B.
    always @(posedge clk) begin
        pa  <= ref_op(a_ui, a_uo);
        pb0 <= ref_op(b_ui, b_uo);
        pb1 <= pb0;
        pb2 <= pb1;
    end

    op_unit_arbiter #(.N_REQ(4), .WIDTH(8), .OPW(3), .UNIT_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(a_req), .req_op(a_op), .req_data(a_data),
`ifdef OP_ARB_LOCK_EN
        .lock(a_lock),
`endif
        .gnt(a_gnt), .rsp_valid(a_rv), .rsp_data(a_rd), .busy(a_busy),
        .unit_in(a_ui), .unit_op(a_uo), .unit_out(pa)
    );

    op_unit_arbiter #(.N_REQ(4), .WIDTH(8), .OPW(3), .UNIT_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(b_req), .req_op(b_op), .req_data(b_data),
`ifdef OP_ARB_LOCK_EN
        .lock(4'b0000),
`endif
        .gnt(b_gnt), .rsp_valid(b_rv), .rsp_data(b_rd), .busy(b_busy),
        .unit_in(b_ui), .unit_op(b_uo), .unit_out(pb2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_gnt != 4'd0) begin
            if (qa_g.size() == 0) chk("a_gnt_unexpected", {28'd0, a_gnt}, 32'd0);
            else begin
                e = qa_g.pop_front();
                chk("a_gnt", {28'd0, a_gnt}, 32'd1 << e.idx);
                chk("a_unit_in", {24'd0, a_ui}, {24'd0, e.din});
                chk("a_unit_op", {29'd0, a_uo}, {29'd0, e.op});
                ga_cyc = cyc;
            end
        end
        if (a_rv != 4'd0) begin
            if (qa_r.size() == 0) chk("a_rsp_unexpected", {28'd0, a_rv}, 32'd0);
            else begin
                e = qa_r.pop_front();
                chk("a_rsp_valid", {28'd0, a_rv}, 32'd1 << e.idx);
                chk("a_rsp_data", {24'd0, a_rd}, {24'd0, e.res});
                chk("a_rsp_latency", cyc - ga_cyc, 32'd2);
            end
        end
        if (b_gnt != 4'd0) begin
            if (qb_g.size() == 0) chk("b_gnt_unexpected", {28'd0, b_gnt}, 32'd0);
            else begin
                e = qb_g.pop_front();
                chk("b_gnt", {28'd0, b_gnt}, 32'd1 << e.idx);
                chk("b_unit_in", {24'd0, b_ui}, {24'd0, e.din});
                chk("b_unit_op", {29'd0, b_uo}, {29'd0, e.op});
                gb_cyc = cyc;
            end
        end
        if (b_rv != 4'd0) begin
            if (qb_r.size() == 0) chk("b_rsp_unexpected", {28'd0, b_rv}, 32'd0);
            else begin
                e = qb_r.pop_front();
                chk("b_rsp_valid", {28'd0, b_rv}, 32'd1 << e.idx);
                chk("b_rsp_data", {24'd0, b_rd}, {24'd0, e.res});
                chk("b_rsp_latency", cyc - gb_cyc, 32'd4);
            end
        end
    end

    task automatic push(input int sel, input int idx, input logic [7:0] din,
                        input logic [2:0] op, input logic [7:0] res);
        exp_t e;
        e.idx = idx; e.din = din; e.op = op; e.res = res;
        if (sel == 0) begin qa_g.push_back(e); qa_r.push_back(e); end
        else begin qb_g.push_back(e); qb_r.push_back(e); end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a_req = '0; b_req = '0; a_lock = '0;
        qa_g.delete(); qa_r.delete(); qb_g.delete(); qb_r.delete();
        repeat (2) @(negedge clk);
        chk("rst_busy", {30'd0, a_busy, b_busy}, 32'd0);
        chk("rst_gnt", {24'd0, a_gnt, b_gnt}, 32'd0);
        chk("rst_rsp_valid", {24'd0, a_rv, b_rv}, 32'd0);
        chk("rst_rsp_data", {16'd0, a_rd, b_rd}, 32'd0);
        chk("rst_unit", {10'd0, a_ui, a_uo, b_ui, b_uo}, 32'd0);
        rst_n = 1'b1;
    endtask

    // Raise req, count n grants (checking 4-cycle spacing), drop req, wait for IDLE.
    task automatic run(input int sel, input logic [3:0] r, input int n, output int first);
        int seen = 0;
        int prev = 0;
        int start = cyc;
        first = -1;
        if (sel == 0) a_req = r; else b_req = r;
        for (int t = 0; t < 400 && seen < n; t++) begin
            @(negedge clk);
            if ((sel == 0 ? a_gnt : b_gnt) != 4'd0) begin
                if (seen == 0) first = cyc - start;
                else if (sel == 0) chk("gnt_spacing", cyc - prev, 32'd4);
                prev = cyc;
                seen++;
            end
        end
        if (sel == 0) a_req = '0; else b_req = '0;
        chk("grant_count", seen, n);
        for (int t = 0; t < 50 && (sel == 0 ? a_busy : b_busy); t++) @(negedge clk);
        chk("return_idle", {31'd0, (sel == 0 ? a_busy : b_busy)}, 32'd0);
    endtask

    initial begin
        int f;
        int waited;
        logic [7:0] res3c [8];
        res3c[0] = 8'h3C; res3c[1] = 8'h3D; res3c[2] = 8'hC3; res3c[3] = 8'h78;
        res3c[4] = 8'h1E; res3c[5] = 8'h66; res3c[6] = 8'hC3; res3c[7] = 8'hC4;

        do_reset();
        a_data = 32'h000000A5; a_op = 12'b000_000_000_010;
        push(0, 0, 8'hA5, 3'b010, 8'h5A);
        run(0, 4'b0001, 1, f);
        chk("first_gnt_cycle", f, 32'd1);

        do_reset();
        a_data = 32'h13121110; a_op = 12'b001_001_001_001;
        push(0, 0, 8'h10, 3'd1, 8'h11);
        push(0, 1, 8'h11, 3'd1, 8'h12);
        push(0, 2, 8'h12, 3'd1, 8'h13);
        push(0, 3, 8'h13, 3'd1, 8'h14);
        push(0, 0, 8'h10, 3'd1, 8'h11);
        run(0, 4'b1111, 5, f);

        do_reset();
        a_data = 32'h80001100; a_op = 12'b100_000_001_000;
        push(0, 1, 8'h11, 3'd1, 8'h12);
        run(0, 4'b0010, 1, f);
        push(0, 3, 8'h80, 3'd4, 8'h40);
        push(0, 1, 8'h11, 3'd1, 8'h12);
        run(0, 4'b1010, 2, f);

        // Asynchronous reset during WAIT discards the in-flight operation.
        a_data = 32'h002A0077; a_op = 12'b000_101_000_000;
        push(0, 0, 8'h77, 3'd0, 8'h77);
        a_req = 4'b0001;
        waited = 0;
        while (a_gnt == 4'd0 && waited < 20) begin @(negedge clk); waited++; end
        chk("wait_gnt_before_reset", {28'd0, a_gnt}, 32'd1);
        @(negedge clk);
        qa_r.delete();
        rst_n = 1'b0;
        a_req = '0;
        #1;
        chk("async_rst_busy", {31'd0, a_busy}, 32'd0);
        chk("async_rst_gnt_rv", {24'd0, a_gnt, a_rv}, 32'd0);
        chk("async_rst_rsp_data", {24'd0, a_rd}, 32'd0);
        chk("async_rst_unit_in", {24'd0, a_ui}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(0, 2, 8'h2A, 3'd5, 8'h70);
        run(0, 4'b0100, 1, f);

        do_reset();
        b_data = 32'h0000003C;
        for (int op = 0; op < 8; op++) begin
            b_op = {9'd0, 3'(op)};
            push(1, 0, 8'h3C, 3'(op), res3c[op]);
            run(1, 4'b0001, 1, f);
        end

`ifdef OP_ARB_LOCK_EN
        do_reset();
        begin
            int seen = 0;
            a_data = 32'h00001101; a_op = 12'b000_000_001_001;
            push(0, 0, 8'h01, 3'd1, 8'h02);
            push(0, 0, 8'h01, 3'd1, 8'h02);
            push(0, 0, 8'h01, 3'd1, 8'h02);
            push(0, 1, 8'h11, 3'd1, 8'h12);
            a_lock = 4'b0001;
            a_req = 4'b0011;
            for (int t = 0; t < 100 && seen < 4; t++) begin
                @(negedge clk);
                if (a_gnt != 4'd0) begin
                    seen++;
                    if (seen == 3) a_lock = 4'b0000;
                end
            end
            a_req = '0;
            chk("lock_grant_count", seen, 32'd4);
            for (int t = 0; t < 50 && a_busy; t++) @(negedge clk);
        end
`endif

        repeat (3) @(negedge clk);
        chk("a_queues_empty", qa_g.size() + qa_r.size(), 32'd0);
        chk("b_queues_empty", qb_g.size() + qb_r.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
